matrix_led_top: RTL and testbench
=================================

// Module: matrix_led_top
//
// PURPOSE
// - Top level of the 8x8 LED-matrix board design. Drives a MAX7219-style serial
//   display controller over a 3-wire interface (CS, CLK_9M, DOUT) from the 27 MHz
//   board clock.
// - After reset it sends a fixed 5-command init sequence, then refreshes the
//   8 row registers forever.
// - The row patterns are a diagonal that advances one position every FRAME_HOLD cycles.
//
// PARAMETERS
// - POWERUP_WAIT  default 270        idle cycles after reset before the first frame (10 us)
// - GAP_CYCLES    default 8          CS-high cycles between consecutive frames
// - FRAME_HOLD    default 2_700_000  cycles a pattern is held (100 ms) before advancing
// - INTENSITY     default 4'h8       value written to the intensity register
//
// PORTS
// - CLK_27M  in   1   system clock, 27 MHz; all logic is on its rising edge
// - RST_N    in   1   synchronous, active-high reset
//                     (reset is asserted while RST_N==1; the name is kept for board compatibility)
// - CS       out  1   frame select / load, active low; device latches the frame on rising edge
// - CLK_9M   out  1   serial clock, CLK_27M/3 while CS is low, held 0 otherwise
// - DOUT     out  1   serial data, MSB first, 16 bits per frame
//
// BEHAVIOUR
// - Reset values: CS=1, CLK_9M=0, DOUT=0.
//   - Reset is sampled every cycle. Asserting it mid-frame aborts at once: CS=1 next cycle.
//   - After reset the sequencer restarts from POWERUP_WAIT, then INIT; the pattern index clears to 0.
// - All outputs are registered; there are no combinational paths from inputs.
// - Frame format {4'h0, addr[3:0], data[7:0]} = 16 bits.
//   - Frame start cycle: CS goes 0, DOUT = bit15, bit phase 0.
//   - Each bit occupies 3 cycles: phase 0, 1 = CLK_9M low, phase 2 = CLK_9M high.
//   - DOUT changes only at phase 0. Bit k is valid for all 3 of its cycles.
//   - After 48 cycles (16 bits), CS returns to 1, DOUT returns to 0, CLK_9M is 0.
//   - CS is then held 1 for GAP_CYCLES before the next frame.
// - Sequencer states, in order:
//   - WAIT: count POWERUP_WAIT cycles.
//   - INIT: send 0x0C01 (shutdown off), 0x0900 (no decode), {0x0A,INTENSITY},
//     0x0B07 (scan all 8), 0x0F00 (test off).
//   - ROWS: send rows r=0..7 as addr=r+1, data = 8'h01 << ((r+pat)%8).
//   - HOLD: count FRAME_HOLD cycles; at the end pat = (pat+1)%8, then go to ROWS.
//   - WAIT -> INIT -> ROWS -> HOLD -> ROWS -> ...; INIT is never repeated except after reset.
// - The HOLD counter starts on the cycle CS rises after row 8.
//   The pattern update and the start of the next ROWS happen on the same cycle.
// - pat is 3 bits; it wraps from 7 to 0.
// - A new frame never starts while the previous frame or its gap is in progress.
//
// STRUCTURE
// - Package matrix_led_pkg:
//   - register address localparams (DIGIT0=1..DIGIT7=8, DECODE=9, INTENSITY=A,
//     SCANLIMIT=B, SHUTDOWN=C, DISPTEST=F)
//   - sequencer state enum
//   - frame typedef (struct addr/data)
// - Sub-module max7219_spi_tx:
//   - inputs: start, frame[15:0]; outputs: busy, done, CS, CLK_9M, DOUT
//   - owns the phase/bit counters and the gap timer
//   - matrix_led_top holds only the sequencer, the row-pattern formula and the hold counter.
//
// TESTING (bench: FRAME_HOLD=2000, POWERUP_WAIT=270)
// - Reset held, then released -> CS=1, CLK_9M=0, DOUT=0 for 270 cycles; first CS fall at cycle 270 after release.
// - Decode frame 1 (sample DOUT on CLK_9M rising) -> 0x0C01. Frames 2-5 -> 0x0900, 0x0A08, 0x0B07, 0x0F00.
// - Frame timing -> CS low for exactly 48 cycles, 16 CLK_9M rising edges,
//   CLK_9M high for 1 of every 3 cycles, CS high >= 8 cycles between frames.
// - Frames 6-13 -> 0x0101, 0x0202, 0x0304 ... 0x0880.
//   After 2000 hold cycles the next 8 frames are 0x0102, 0x0204, ..., 0x0801.
// - Run 8 hold periods -> the row-1 data sequence is 01,02,04,...,80,01 (pat wrap).
// - Reset asserted at bit 7 of a row frame -> CS=1 next cycle; after release the sequence restarts with 270 idle cycles, then 0x0C01.

Source files
------------

// File: rtl/matrix_led_pkg.sv
// Shared definitions for the 8x8 LED-matrix driver: register map, sequencer states,
// frame layout and the row-pattern formula.
package matrix_led_pkg;

    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DIGIT7    = 4'h8;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_DISPTEST  = 4'hF;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_INIT,
        ST_ROWS,
        ST_HOLD
    } seq_state_t;

    typedef struct packed {
        logic [3:0] pad;
        logic [3:0] addr;
        logic [7:0] data;
    } frame_t;

    // Row r lights column (r + pat) mod 8; the 3-bit sum wraps naturally.
    function automatic frame_t row_frame(input logic [2:0] row, input logic [2:0] pat);
        frame_t     f;
        logic [2:0] col;
        col    = row + pat;
        f.pad  = 4'h0;
        f.addr = REG_DIGIT0 + {1'b0, row};
        f.data = 8'h01 << col;
        return f;
    endfunction

endpackage

// File: rtl/matrix_led_top_spi_tx.sv
// Serial transmitter for one 16-bit MAX7219 frame: CS low for 48 cycles, CLK_9M at
// clk/3 (high on the third cycle of each bit), MSB first, followed by a CS-high gap.
module max7219_spi_tx #(
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] frame,
    output logic        busy,
    output logic        done,
    output logic        CS,
    output logic        CLK_9M,
    output logic        DOUT
);

    localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    logic          in_frame;
    logic [1:0]    phase;
    logic [3:0]    bit_cnt;
    logic [14:0]   shreg;
    logic [GW-1:0] gap_cnt;

    // Last cycle of the frame; CS rises on the edge that samples this.
    assign done = in_frame && (phase == 2'd2) && (bit_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            in_frame <= 1'b0;
            phase    <= 2'd0;
            bit_cnt  <= 4'd0;
            shreg    <= '0;
            gap_cnt  <= '0;
            CS       <= 1'b1;
            CLK_9M   <= 1'b0;
            DOUT     <= 1'b0;
        end else if (in_frame) begin
            case (phase)
                2'd0: phase <= 2'd1;
                2'd1: begin
                    phase  <= 2'd2;
                    CLK_9M <= 1'b1;
                end
                default: begin
                    phase  <= 2'd0;
                    CLK_9M <= 1'b0;
                    if (bit_cnt == 4'd15) begin
                        in_frame <= 1'b0;
                        CS       <= 1'b1;
                        DOUT     <= 1'b0;
                        gap_cnt  <= GW'(GAP_CYCLES - 1);
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        DOUT    <= shreg[14];
                        shreg   <= {shreg[13:0], 1'b0};
                    end
                end
            endcase
        end else if (busy) begin
            // busy drops one cycle early so the next CS fall lands exactly GAP_CYCLES later.
            gap_cnt <= gap_cnt - 1'b1;
            if (gap_cnt <= GW'(1))
                busy <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
            in_frame <= 1'b1;
            phase    <= 2'd0;
            bit_cnt  <= 4'd0;
            CS       <= 1'b0;
            DOUT     <= frame[15];
            shreg    <= frame[14:0];
        end
    end

endmodule

// File: rtl/matrix_led_top.sv
// Board top: power-up wait, five-frame MAX7219 init, then endless refresh of the 8 rows
// with a diagonal pattern that steps every FRAME_HOLD cycles.
module matrix_led_top
    import matrix_led_pkg::*;
#(
    parameter int unsigned POWERUP_WAIT = 270,
    parameter int unsigned GAP_CYCLES   = 8,
    parameter int unsigned FRAME_HOLD   = 2_700_000,
    parameter logic [3:0]  INTENSITY    = 4'h8
) (
    input  logic CLK_27M,
    input  logic RST_N,
    output logic CS,
    output logic CLK_9M,
    output logic DOUT
);

    localparam int unsigned CNT_MAX = (POWERUP_WAIT > FRAME_HOLD) ? POWERUP_WAIT : FRAME_HOLD;
    localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    seq_state_t    state;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [2:0]    pat;
    logic          busy;
    logic          done;
    logic          start;
    frame_t        frame;

    always_comb begin
        frame = '0;
        start = 1'b0;
        case (state)
            ST_INIT: begin
                start = !busy;
                case (idx[2:0])
                    3'd0:    frame = {4'h0, REG_SHUTDOWN,  8'h01};
                    3'd1:    frame = {4'h0, REG_DECODE,    8'h00};
                    3'd2:    frame = {4'h0, REG_INTENSITY, 4'h0, INTENSITY};
                    3'd3:    frame = {4'h0, REG_SCANLIMIT, 8'h07};
                    default: frame = {4'h0, REG_DISPTEST,  8'h00};
                endcase
            end
            ST_ROWS: begin
                start = !busy && !idx[3];
                frame = row_frame(idx[2:0], pat);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_27M) begin
        if (RST_N) begin
            state <= ST_WAIT;
            cnt   <= '0;
            idx   <= 4'd0;
            pat   <= 3'd0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (cnt == CW'(POWERUP_WAIT - 1)) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_INIT: begin
                    if (start) begin
                        if (idx == 4'd4) begin
                            idx   <= 4'd0;
                            state <= ST_ROWS;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                ST_ROWS: begin
                    // idx reaches 8 once row 8 is accepted; hold starts as that frame ends.
                    if (start) begin
                        idx <= idx + 4'd1;
                    end else if (idx[3] && done) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (cnt == CW'(FRAME_HOLD - 1)) begin
                        pat   <= pat + 3'd1;
                        idx   <= 4'd0;
                        cnt   <= '0;
                        state <= ST_ROWS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    max7219_spi_tx #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_tx (
        .clk   (CLK_27M),
        .rst   (RST_N),
        .start (start),
        .frame (frame),
        .busy  (busy),
        .done  (done),
        .CS    (CS),
        .CLK_9M(CLK_9M),
        .DOUT  (DOUT)
    );

endmodule

// File: tb/tb_matrix_led_top.sv
// Directed bench for matrix_led_top: decodes every serial frame, checks frame timing,
// init sequence, row patterns across a full pattern wrap, and mid-frame reset.
module tb_matrix_led_top;

    logic clk = 1'b0;
    logic rst;
    logic cs, sclk, dout;

    int errors = 0;
    int checks = 0;

    matrix_led_top #(
        .POWERUP_WAIT(270),
        .GAP_CYCLES  (8),
        .FRAME_HOLD  (2000),
        .INTENSITY   (4'h8)
    ) dut (
        .CLK_27M(clk),
        .RST_N  (rst),
        .CS     (cs),
        .CLK_9M (sclk),
        .DOUT   (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts sampling at the current negedge; returns positioned on the first CS-high
    // sample after the frame, which counts toward the next frame's gap.
    task automatic capture(input int limit, output logic [15:0] word, output int gap,
                           output int low, output int rises, output int highs,
                           output bit idle_bad, output bit tmo);
        logic prev;
        int   n;
        word = '0; gap = 0; low = 0; rises = 0; highs = 0;
        idle_bad = 1'b0; tmo = 1'b0; prev = 1'b0; n = 0;
        while (cs === 1'b1 && n < limit) begin
            if (sclk !== 1'b0 || dout !== 1'b0) idle_bad = 1'b1;
            gap++; n++;
            @(negedge clk);
        end
        while (cs === 1'b0 && n < limit) begin
            low++; n++;
            if (sclk === 1'b1) begin
                highs++;
                if (prev === 1'b0) begin
                    rises++;
                    word = {word[14:0], dout};
                end
            end
            prev = sclk;
            @(negedge clk);
        end
        if (n >= limit || cs !== 1'b1) tmo = 1'b1;
    endtask

    task automatic grab(input string tag, input logic [15:0] exp_word,
                        input int min_gap, input int max_gap, output logic [15:0] word);
        int gap, low, rises, highs;
        bit idle_bad, tmo;
        capture(5000, word, gap, low, rises, highs, idle_bad, tmo);
        chk({tag, "_timeout"}, 32'(tmo), 32'd0);
        chk({tag, "_word"}, 32'(word), 32'(exp_word));
        chk({tag, "_cs_low"}, 32'(low), 32'd48);
        chk({tag, "_rises"}, 32'(rises), 32'd16);
        chk({tag, "_sclk_high"}, 32'(highs), 32'd16);
        chk({tag, "_gap_range"}, 32'(gap >= min_gap && gap <= max_gap), 32'd1);
        chk({tag, "_idle_quiet"}, 32'(idle_bad), 32'd0);
    endtask

    logic [15:0] init_words [0:4] = '{16'h0C01, 16'h0900, 16'h0A08, 16'h0B07, 16'h0F00};
    logic [7:0]  row1_seq   [0:8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

    initial begin
        logic [15:0] w;
        logic [15:0] exp_w;
        logic [7:0]  col;
        int          n;

        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);

        rst = 1'b0;
        @(negedge clk);
        grab("init0", init_words[0], 270, 270, w);
        for (int i = 1; i < 5; i++)
            grab($sformatf("init%0d", i), init_words[i], 8, 20, w);

        // Patterns 0..7 and the wrap back to 0; each set preceded by the power-up
        // init gap (first) or a full hold period.
        for (int p = 0; p < 9; p++) begin
            for (int r = 0; r < 8; r++) begin
                col   = 8'h01 << ((r + p) % 8);
                exp_w = {4'h0, 4'(r + 1), col};
                if (r == 0 && p > 0)
                    grab($sformatf("p%0d_r%0d", p, r), exp_w, 2000, 2100, w);
                else
                    grab($sformatf("p%0d_r%0d", p, r), exp_w, 8, 20, w);
                if (r == 0)
                    chk($sformatf("row1_seq%0d", p), 32'(w[7:0]), 32'(row1_seq[p]));
            end
        end

        // Abort a row frame at bit 7 (21 cycles after the CS fall sample).
        n = 0;
        while (cs === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("abort_wait_timeout", 32'(n >= 5000), 32'd0);
        repeat (21) @(negedge clk);
        chk("abort_mid_cs", 32'(cs), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cs", 32'(cs), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_dout", 32'(dout), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        grab("rst2_init0", 16'h0C01, 270, 270, w);
        grab("rst2_init1", 16'h0900, 8, 20, w);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
